// File: rtl/das_mem_arbiter_if.sv
// Bundle of the writer, host-reader, memory and status signals around das_mem_arbiter.
// slave = arbiter side, master = requesters plus the memory that answers read accesses.
interface das_mem_arbiter_if #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 2
);
    // Handshake: a requester raises wr_req (with wr_data) or rd_req and holds it until
    // wr_gnt / rd_valid pulses for one cycle, then drops it on the edge ending that cycle.
    // A request still high in the next idle cycle is taken as a new access.
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              ovf_clr;
    logic [1:0]        fsm_state;

    modport slave (
        input  wr_req, wr_data, rd_req, mem_rdata, ovf_clr,
        output wr_gnt, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
               count, full, empty, overflow, fsm_state
    );

    modport master (
        output wr_req, wr_data, rd_req, mem_rdata, ovf_clr,
        input  wr_gnt, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
               count, full, empty, overflow, fsm_state
    );
endinterface

// File: rtl/das_mem_arbiter.sv
// Round-robin arbiter that shares a single-port sample memory between the acquisition
// writer and the host reader, keeping the memory as a circular FIFO.
module das_mem_arbiter #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic reset,
    das_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RDW = 2'd3} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;
    logic              prio_wr;
    logic              wr_gnt_r;
    logic              rd_valid_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic full_w;
    logic empty_w;
    logic wr_ok;
    logic rd_ok;

    assign full_w  = (cnt == (ADDR_W+1)'(DEPTH));
    assign empty_w = (cnt == '0);
    assign wr_ok   = bus.wr_req & ~full_w;
    assign rd_ok   = bus.rd_req & ~empty_w;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Access strobes are decided on the edge entering WR/RD so every memory-side
    // output comes straight from a flop; mem_wdata doubles as the write holding register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            prio_wr     <= 1'b1;
            wr_gnt_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            wr_gnt_r   <= 1'b0;
            rd_valid_r <= 1'b0;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;

            if (state == IDLE && bus.wr_req && full_w) begin
                ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (wr_ok && (!rd_ok || prio_wr)) begin
                        state       <= WR;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= wr_ptr;
                        mem_wdata_r <= bus.wr_data;
                        wr_gnt_r    <= 1'b1;
                    end else if (rd_ok) begin
                        state      <= RD;
                        mem_en_r   <= 1'b1;
                        mem_addr_r <= rd_ptr;
                    end
                end
                WR: begin
                    wr_ptr  <= ptr_next(wr_ptr);
                    cnt     <= cnt + 1'b1;
                    prio_wr <= 1'b0;
                    state   <= IDLE;
                end
                RD: begin
                    rd_ptr     <= ptr_next(rd_ptr);
                    cnt        <= cnt - 1'b1;
                    prio_wr    <= 1'b1;
                    rd_valid_r <= 1'b1;
                    state      <= RDW;
                end
                RDW: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_gnt    = wr_gnt_r;
    assign bus.rd_valid  = rd_valid_r;
    // The memory answers one cycle after the RD access, which is exactly the RDW cycle.
    assign bus.rd_data   = rd_valid_r ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.count     = cnt;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.overflow  = ovf;
    assign bus.fsm_state = state;
endmodule
